// File: rtl/drm_activator_bus_master.sv
// Bit-serial slave-bus master for the DRM activator: word commands become
// four-phase, one-bit-per-handshake bus levels carried as AXI4-Stream snapshots.
module drm_activator_bus_master #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  drm_aclk,
  input  logic                  drm_arstn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_we,
  input  logic [1:0]            cmd_adr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_sta,
  output logic                  rsp_timeout,
  output logic                  intr,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic [31:0]           m_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic [31:0]           s_tdata
);

  localparam int IDXW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int PHW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam int TOM1 = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(DATA_WIDTH - 1);
  localparam logic [PHW-1:0]  PHASE_LIMIT = PHW'(TOM1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_REL,
    S_DONE
  } state_t;

  state_t                r_state, w_state;
  logic                  r_run;
  logic                  r_we, w_we;
  logic [1:0]            r_adr, w_adr;
  logic [DATA_WIDTH-1:0] r_wdata, w_wdata;
  logic [IDXW-1:0]       r_idx, w_idx, w_nextIdx;
  logic [PHW-1:0]        r_phase, w_phase, w_phaseSat;
  logic [31:0]           r_mdata, w_mdata;
  logic [DATA_WIDTH-1:0] r_rdata, w_rdata;
  logic                  r_sta, w_sta;
  logic                  r_timeout, w_timeout;
  logic                  r_intr, w_intr;
  logic                  w_beat;
  logic                  w_phaseHit;
  logic                  w_unused;

  // Bus level snapshot: CS and CYC always move together.
  function automatic logic [31:0] f_level(input logic sel, input logic [1:0] adr,
                                          input logic we, input logic dat);
    f_level = {26'd0, sel, sel, adr, we, dat};
  endfunction

  assign w_unused = ^{m_tready, s_tdata[31:4]};
  assign w_beat   = s_tvalid & r_run;

  always_ff @(posedge drm_aclk or negedge drm_arstn) begin
    if (!drm_arstn) r_state <= S_IDLE;
    else            r_state <= w_state;
  end

  always_comb begin
    w_state    = r_state;
    w_we       = r_we;
    w_adr      = r_adr;
    w_wdata    = r_wdata;
    w_idx      = r_idx;
    w_phase    = r_phase;
    w_mdata    = r_mdata;
    w_rdata    = r_rdata;
    w_sta      = r_sta;
    w_timeout  = r_timeout;
    w_intr     = r_intr;
    w_nextIdx  = r_idx + IDXW'(1);
    w_phaseSat = (r_phase == {PHW{1'b1}}) ? r_phase : r_phase + PHW'(1);
    w_phaseHit = TIMEOUT_EN && (r_phase == PHASE_LIMIT);

    if (w_beat) w_intr = s_tdata[2];

    case (r_state)
      S_IDLE: begin
        if (cmd_valid && r_run) begin
          w_we      = cmd_we;
          w_adr     = cmd_adr;
          w_wdata   = cmd_wdata;
          w_idx     = '0;
          w_phase   = '0;
          w_rdata   = '0;
          w_sta     = 1'b0;
          w_timeout = 1'b0;
          w_mdata   = f_level(1'b1, cmd_adr, cmd_we, cmd_wdata[0]);
          w_state   = S_REQ;
        end
      end
      S_REQ: begin
        if (w_beat && s_tdata[3]) begin
          w_rdata[r_idx] = s_tdata[0];
          w_sta          = r_sta | s_tdata[1];
          w_mdata        = f_level(1'b0, r_adr, r_we, 1'b0);
          w_phase        = '0;
          w_state        = S_REL;
        end else if (w_phaseHit) begin
          w_timeout = 1'b1;
          w_mdata   = '0;
          w_state   = S_DONE;
        end else begin
          w_phase = w_phaseSat;
        end
      end
      S_REL: begin
        if (w_beat && !s_tdata[3]) begin
          if (r_idx == LAST_IDX) begin
            w_mdata = '0;
            w_state = S_DONE;
          end else begin
            w_idx   = w_nextIdx;
            w_mdata = f_level(1'b1, r_adr, r_we, r_wdata[w_nextIdx]);
            w_phase = '0;
            w_state = S_REQ;
          end
        end else if (w_phaseHit) begin
          w_timeout = 1'b1;
          w_mdata   = '0;
          w_state   = S_DONE;
        end else begin
          w_phase = w_phaseSat;
        end
      end
      S_DONE: begin
        if (rsp_ready) w_state = S_IDLE;
      end
      default: w_state = S_IDLE;
    endcase
  end

  // r_run holds both streams off until the first clock after reset release.
  always_ff @(posedge drm_aclk or negedge drm_arstn) begin
    if (!drm_arstn) begin
      r_run     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdata   <= '0;
      r_idx     <= '0;
      r_phase   <= '0;
      r_mdata   <= '0;
      r_rdata   <= '0;
      r_sta     <= 1'b0;
      r_timeout <= 1'b0;
      r_intr    <= 1'b0;
    end else begin
      r_run     <= 1'b1;
      r_we      <= w_we;
      r_adr     <= w_adr;
      r_wdata   <= w_wdata;
      r_idx     <= w_idx;
      r_phase   <= w_phase;
      r_mdata   <= w_mdata;
      r_rdata   <= w_rdata;
      r_sta     <= w_sta;
      r_timeout <= w_timeout;
      r_intr    <= w_intr;
    end
  end

  assign cmd_ready   = r_run && (r_state == S_IDLE);
  assign rsp_valid   = (r_state == S_DONE);
  assign rsp_rdata   = r_rdata;
  assign rsp_sta     = r_sta;
  assign rsp_timeout = r_timeout;
  assign intr        = r_intr;
  assign m_tvalid    = r_run;
  assign s_tready    = r_run;
  assign m_tdata     = r_mdata;

endmodule

// File: tb/tb_drm_activator_bus_master.sv
// Directed bench for drm_activator_bus_master with a behavioural activator
// responder (echo/read data, STA, missing ACK, stale ACK, INTR pattern).
module tb_drm_activator_bus_master;

  logic        drm_aclk = 1'b0;
  logic        drm_arstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [1:0]  cmd_adr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_sta;
  logic        rsp_timeout;
  logic        intr;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;

  int assertCount = 0;
  int failCount   = 0;
  int cycleNo     = 0;
  int acceptCyc   = 0;
  int latency;
  int relCycles;
  logic expI;

  // responder configuration and state
  bit          rspOn = 1'b0;
  bit          useEcho;
  logic [31:0] rspWord;
  int          staBit;
  int          noAckBit;
  int          staleExtra;
  logic [7:0]  intrPattern = 8'b1011_0010;
  int          bitCnt = 0;
  int          staleRem = 0;
  int          beatCnt = 0;
  logic [31:0] prevLvl = '0;
  logic [31:0] seqWord = '0;
  logic        weSeen = 1'b0;
  logic [1:0]  adrSeen = '0;
  logic        rAck, rDat, rSta;

  drm_activator_bus_master #(
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .drm_aclk   (drm_aclk),
    .drm_arstn  (drm_arstn),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_we     (cmd_we),
    .cmd_adr    (cmd_adr),
    .cmd_wdata  (cmd_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_sta    (rsp_sta),
    .rsp_timeout(rsp_timeout),
    .intr       (intr),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata)
  );

  always #5 drm_aclk = ~drm_aclk;

  initial forever begin
    @(posedge drm_aclk);
    cycleNo++;
  end

  // Activator model: answers the level seen one cycle earlier, so ACK lags CS by a cycle.
  initial begin
    s_tvalid = 1'b0;
    s_tdata  = '0;
    forever begin
      @(negedge drm_aclk);
      if (cmd_ready || !drm_arstn) begin
        bitCnt   = 0;
        staleRem = 0;
        weSeen   = 1'b0;
      end
      if (rspOn) begin
        rAck = prevLvl[5] & prevLvl[4] & (bitCnt != noAckBit);
        if (rAck) staleRem = staleExtra;
        else if (staleRem > 0) begin
          rAck = 1'b1;
          staleRem--;
        end
        rDat = useEcho ? prevLvl[0] : rspWord[bitCnt[4:0]];
        rSta = rAck && (bitCnt == staBit);
        s_tvalid = 1'b1;
        s_tdata  = {28'd0, rAck, intrPattern[beatCnt % 8], rSta, rDat};
        beatCnt++;
        if (prevLvl[5]) begin
          seqWord[bitCnt[4:0]] = prevLvl[0];
          if (prevLvl[1]) weSeen = 1'b1;
          adrSeen = prevLvl[3:2];
        end
        if (prevLvl[5] && !m_tdata[5]) bitCnt++;
      end
      prevLvl = m_tdata;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    assertCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [1:0] adr, input logic [31:0] wdata);
    int n;
    @(negedge drm_aclk);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_wdata = wdata;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge drm_aclk);
      n++;
    end
    @(posedge drm_aclk);
    #1;
    cmd_valid = 1'b0;
    acceptCyc = cycleNo;
    checkOutput("reqLevelBit0", m_tdata, {26'd0, 2'b11, adr, we, wdata[0]});
  endtask

  task automatic waitRsp(output int lat);
    int n;
    n = 0;
    while (!rsp_valid && n < 1000) begin
      @(posedge drm_aclk);
      #1;
      n++;
    end
    lat = cycleNo - acceptCyc;
    checkOutput("rspValid", rsp_valid, 1);
    checkOutput("mtdataIdleDone", m_tdata, 0);
  endtask

  task automatic finishRsp();
    checkOutput("cmdReadyInDone", cmd_ready, 0);
    @(negedge drm_aclk);
    rsp_ready = 1'b1;
    @(posedge drm_aclk);
    #1;
    rsp_ready = 1'b0;
    checkOutput("cmdReadyAfterRsp", cmd_ready, 1);
    checkOutput("rspValidAfterRsp", rsp_valid, 0);
  endtask

  initial begin
    drm_arstn  = 1'b1;
    cmd_valid  = 1'b0;
    cmd_we     = 1'b0;
    cmd_adr    = '0;
    cmd_wdata  = '0;
    rsp_ready  = 1'b0;
    m_tready   = 1'b1;
    useEcho    = 1'b1;
    rspWord    = '0;
    staBit     = -1;
    noAckBit   = -1;
    staleExtra = 0;
    #1 drm_arstn = 1'b0;

    // reset values
    repeat (2) @(negedge drm_aclk);
    checkOutput("resetCtrl", {m_tvalid, s_tready, cmd_ready, rsp_valid, rsp_sta, rsp_timeout, intr}, 0);
    checkOutput("resetMtdata", m_tdata, 0);
    checkOutput("resetRdata", rsp_rdata, 0);
    drm_arstn = 1'b1;
    #1 checkOutput("mtvalidBeforeClk", m_tvalid, 0);
    @(posedge drm_aclk);
    #1;
    checkOutput("mtvalidAfterRst", {m_tvalid, s_tready}, 2'b11);
    checkOutput("cmdReadyAfterRst", cmd_ready, 1);
    rspOn = 1'b1;

    // write with echo responder
    $display("[TB] write 0xA5A50F0F to adr 2");
    applyStimulus(1'b1, 2'd2, 32'hA5A5_0F0F);
    waitRsp(latency);
    checkOutput("writeLatency", latency, 128);
    checkOutput("writeDatSeq", seqWord, 32'hA5A5_0F0F);
    checkOutput("writeRdata", rsp_rdata, 32'hA5A5_0F0F);
    checkOutput("writeSta", rsp_sta, 0);
    checkOutput("writeTimeout", rsp_timeout, 0);
    checkOutput("writeAdr", adrSeen, 2);
    finishRsp();

    // read with STA on bit 7, INTR tracked beat for beat
    $display("[TB] read adr 1, STA on bit 7");
    useEcho = 1'b0;
    rspWord = 32'h1234_5678;
    staBit  = 7;
    applyStimulus(1'b0, 2'd1, 32'h0);
    for (int i = 0; i < 8; i++) begin
      @(posedge drm_aclk);
      expI = s_tdata[2];
      #1;
      checkOutput("intrTrack", intr, expI);
    end
    waitRsp(latency);
    checkOutput("readRdata", rsp_rdata, 32'h1234_5678);
    checkOutput("readSta", rsp_sta, 1);
    checkOutput("readWeNeverSet", weSeen, 0);
    checkOutput("readAdr", adrSeen, 1);
    finishRsp();

    // stale ACK beats after release
    $display("[TB] stale ACK, 5 extra beats");
    useEcho    = 1'b1;
    staBit     = -1;
    staleExtra = 5;
    applyStimulus(1'b1, 2'd3, 32'h0000_00FF);
    for (int n = 0; n < 20 && m_tdata[5]; n++) begin
      @(posedge drm_aclk);
      #1;
    end
    relCycles = 0;
    while (!m_tdata[5] && relCycles < 30) begin
      @(posedge drm_aclk);
      #1;
      relCycles++;
    end
    checkOutput("staleRelCycles", relCycles, 7);
    waitRsp(latency);
    checkOutput("staleLatency", latency, 288);
    checkOutput("staleRdata", rsp_rdata, 32'h0000_00FF);
    checkOutput("staClearedNextCmd", rsp_sta, 0);
    finishRsp();

    // timeout on bit 3
    $display("[TB] no ACK for bit 3");
    staleExtra = 0;
    noAckBit   = 3;
    applyStimulus(1'b1, 2'd0, 32'hFFFF_FFFF);
    waitRsp(latency);
    checkOutput("timeoutLatency", latency, 20);
    checkOutput("timeoutFlag", rsp_timeout, 1);
    checkOutput("timeoutRdata", rsp_rdata, 32'h0000_0007);
    finishRsp();

    // reset during bit 10
    $display("[TB] reset mid-command");
    noAckBit = -1;
    applyStimulus(1'b1, 2'd2, 32'hFFFF_FFFF);
    for (int n = 0; n < 200 && bitCnt != 10; n++) begin
      @(posedge drm_aclk);
      #1;
    end
    repeat (2) begin
      @(posedge drm_aclk);
      #1;
    end
    drm_arstn = 1'b0;
    #1;
    checkOutput("midRstCtrl", {m_tvalid, s_tready, cmd_ready, rsp_valid, rsp_sta, rsp_timeout, intr}, 0);
    checkOutput("midRstMtdata", m_tdata, 0);
    checkOutput("midRstRdata", rsp_rdata, 0);
    @(negedge drm_aclk);
    drm_arstn = 1'b1;
    #1 checkOutput("midRstMtvalidHeld", m_tvalid, 0);
    @(posedge drm_aclk);
    #1;
    checkOutput("midRstMtvalid", m_tvalid, 1);
    checkOutput("midRstCmdReady", cmd_ready, 1);
    repeat (4) @(posedge drm_aclk);
    #1;
    checkOutput("midRstNoRsp", rsp_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/drm_activator_bus_master.md
# drm_activator_bus_master

Controller-side master for the DRM activator's bit-serial slave bus. It turns word-level register commands (read/write, 2-bit address) into a four-phase, one-bit-per-handshake bus sequence. It sends bus levels to the activator as 32-bit AXI4-Stream snapshots and decodes the activator's ACK/STA/INTR/DAT response stream. It sits in the DRM controller clock domain, directly facing the activator's `drm_to_uip` / `uip_to_drm` stream pair.

## Interface

Parameters:
- `DATA_WIDTH`, 32, bits per command word; legal range 1..64.
- `TIMEOUT_CYCLES`, 1024, maximum cycles spent in one handshake phase before abort. 0 disables the timeout.

Ports:
- `drm_aclk`  in  1  sole clock.
- `drm_arstn`  in  1  asynchronous, active-low reset.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  command accepted when both are high.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  2  activator register address.
- `cmd_wdata`  in  DATA_WIDTH  write data, sent LSB first.
- `rsp_valid`  out  1  response available; held until `rsp_ready`.
- `rsp_ready`  in  1  response consumed.
- `rsp_rdata`  out  DATA_WIDTH  read data, LSB first. Also captured on writes.
- `rsp_sta`  out  1  OR of STA over all ACK beats of the command.
- `rsp_timeout`  out  1  command aborted by timeout.
- `intr`  out  1  INTR bit of the most recent received beat.
- `m_tvalid`  out  1  stream to activator.
- `m_tready`  in  1  stream to activator.
- `m_tdata`  out  32  bus level to activator: [5] CS, [4] CYC, [3:2] ADR, [1] WE, [0] DAT, [31:6] = 0.
- `s_tvalid`  in  1  stream from activator.
- `s_tready`  out  1  stream from activator.
- `s_tdata`  in  32  activator response: [3] ACK, [2] INTR, [1] STA, [0] DAT; [31:4] ignored.

## Operation

- **Reset values.**
  - `m_tvalid` = 0, `m_tdata` = 0, `s_tready` = 0.
  - `cmd_ready` = 0, `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_sta` = 0, `rsp_timeout` = 0, `intr` = 0.
  - State = IDLE.
- **After reset.**
  - From the first clock after deassertion, `m_tvalid` = 1 and `s_tready` = 1, held constantly.
  - `m_tdata` is a registered level. It changes only on the state transitions below and is otherwise held regardless of `m_tready`.
- **Received beat.** A beat counts when `s_tvalid` = 1 (since `s_tready` = 1). Every received beat updates `intr` <= `s_tdata[2]`.
- **States.**
  - **IDLE:** `cmd_ready` = 1; `m_tdata` idle (CS = CYC = 0). On accept:
    - latch `cmd_we`, `cmd_adr`, `cmd_wdata`;
    - bit index <= 0; clear `rsp_sta`, `rsp_timeout`, `rsp_rdata`;
    - `m_tdata` <= {CS = 1, CYC = 1, ADR, WE, DAT = wdata[0]}; go to REQ.
  - **REQ:** wait for a received beat with ACK = 1. On it:
    - `rsp_rdata[idx]` <= `s_tdata[0]`; `rsp_sta` |= `s_tdata[1]`;
    - `m_tdata` <= CS = CYC = 0 (ADR and WE held, DAT = 0); go to REL.
  - **REL:** wait for a received beat with ACK = 0. On it:
    - if idx = DATA_WIDTH-1, go to DONE;
    - else idx++, `m_tdata` <= REQ level with DAT = wdata[idx+1], go to REQ.
  - **DONE:** `rsp_valid` = 1, `m_tdata` idle. On `rsp_ready`, go to IDLE.
- **Timeout.**
  - A phase counter clears on entry to REQ or REL and increments every cycle spent there.
  - When it reaches TIMEOUT_CYCLES (non-zero), go to DONE with `rsp_timeout` = 1.
  - `m_tdata` goes idle on that transition; bits not yet captured in `rsp_rdata` stay 0.
- **Beats ignored.** Beats with ACK = 0 in REQ, and with ACK = 1 in REL, cause no transition. They still update `intr`.
- **Reset mid-command.** Asynchronous return to the reset values. No partial response is emitted.
- **Counter widths.**
  - idx is clog2(DATA_WIDTH), minimum 1.
  - The phase counter is clog2(TIMEOUT_CYCLES+1), minimum 1, and saturates.

## Timing

- **Accept to bus.** Command accepted at cycle 0 → `m_tdata` shows REQ level for bit 0 at cycle 1.
- **Phase transitions.**
  - ACK = 1 received in REQ at cycle t → release level at t+1.
  - ACK = 0 received in REL at cycle t → next REQ level, or `rsp_valid`, at t+1.
- **Minimum per bit.** 2 cycles per bit with a zero-latency responder, so minimum command latency is 2·DATA_WIDTH + 1 cycles from accept to `rsp_valid`.
- **Response to next command.** `rsp_valid` and `rsp_ready` both high at cycle t → `cmd_ready` = 1 at t+1. Back-to-back commands are never accepted in the same cycle as a response handshake.
- **Registered outputs.** All outputs are registered except `cmd_ready` and `rsp_valid`, which decode the registered state.

## Test plan

- **Write with echo responder.**
  - Responder sets ACK = CS·CYC one cycle later and echoes DAT.
  - Stimulus: write 0xA5A5_0F0F to adr 2 (DATA_WIDTH = 32).
  - Required: the DAT sequence on `m_tdata[0]` is 0xA5A5_0F0F LSB first; `rsp_rdata` = 0xA5A5_0F0F; `rsp_sta` = 0; 128-cycle bit phase total.
- **Read.**
  - Responder returns DAT from a stored 0x1234_5678; command is read adr 1, WE = 0.
  - Required: `m_tdata[1]` = 0 throughout; `rsp_rdata` = 0x1234_5678.
- **STA reporting.** Responder asserts STA only on the ACK of bit 7 → `rsp_sta` = 1 at DONE. The next command's response shows `rsp_sta` = 0.
- **Timeout.**
  - TIMEOUT_CYCLES = 8; responder never ACKs bit 3.
  - Required: `rsp_timeout` = 1 eight cycles after entering REQ for bit 3; `rsp_rdata[2:0]` captured, upper bits 0; `m_tdata` idle.
- **Stale ACK and INTR.**
  - Responder holds ACK = 1 for 5 extra beats after release.
  - Required: the next bit's REQ appears only one cycle after the first ACK = 0 beat. `intr` tracks the INTR pulses beat for beat.
- **Reset mid-command.** Assert `drm_arstn` = 0 during bit 10 → all outputs read 0 in the same cycle. After release: `m_tvalid` = 1 on the next clock and `cmd_ready` = 1; no `rsp_valid`.
